cdc_handshake_dest: RTL

- Destination-domain receiver of a 4-phase req/ack multi-bit CDC handshake.
- The source domain holds a data bus stable and raises a request.
- This block synchronizes the request into dest_clk, captures the bus once per transfer, presents it locally, and returns a registered acknowledge to the source domain.
- Used wherever a multi-bit control/status word crosses into the tx_intf clock domain and a plain per-bit synchronizer is not safe.

---
 rtl/cdc_handshake_dest.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cdc_handshake_dest.sv
// cdc_handshake_dest: destination side of a 4-phase req/ack multi-bit CDC.
// Syncs src_req into dest_clk, captures src_in once per transfer, acks back.
//
// Parameters:
//   WIDTH         data bus width (1-1024)
//   DEST_SYNC_FF  synchronizer depth on src_req (2-10)
//   DEST_EXT_HSK  0: dest_req is a 1-cycle pulse
//                 1: dest_req held until dest_ack
//
// Ports:
//   dest_clk  destination clock (only clock)
//   dest_rst  async active-high reset
//   src_req   source request (async to dest_clk)
//   src_in    source data, stable while src_req is high
//   dest_ack  local ack, used only with DEST_EXT_HSK=1
//   dest_out  captured data (registered)
//   dest_req  new data valid on dest_out
//   src_rcv   ack to source domain, straight from a flop
//   busy      FSM not in IDLE
//   err_cnt   protocol-violation count, saturating at 255
//             (present only when CDC_HS_DEST_ERR_CNT_EN is defined)

module cdc_handshake_dest #(
  parameter int WIDTH        = 32,
  parameter int DEST_SYNC_FF = 3,
  parameter int DEST_EXT_HSK = 0
) (
  input  logic             dest_clk,
  input  logic             dest_rst,
  input  logic             src_req,
  input  logic [WIDTH-1:0] src_in,
  input  logic             dest_ack,
  output logic [WIDTH-1:0] dest_out,
  output logic             dest_req,
  output logic             src_rcv,
  output logic             busy
`ifdef CDC_HS_DEST_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam bit EXT = (DEST_EXT_HSK != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ACK      = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DEST_SYNC_FF-1:0] sync_q;
  logic req_s;
  logic req_s_d;
  logic rise;

  logic dest_req_d;
  logic src_rcv_d;
  logic cap;

  // src_req synchronizer; req_s is the last stage
  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      sync_q  <= '0;
      req_s_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[DEST_SYNC_FF-2:0], src_req};
      req_s_d <= req_s;
    end
  end

  assign req_s = sync_q[DEST_SYNC_FF-1];
  assign rise  = req_s & ~req_s_d;

  // next-state and next-output logic; all outputs
  // are registered below so no input reaches an
  // output combinationally
  always_comb begin
    state_d    = state_q;
    dest_req_d = 1'b0;
    src_rcv_d  = src_rcv;
    cap        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cap        = 1'b1;
          dest_req_d = 1'b1;
          if (EXT) begin
            state_d = WAIT_ACK;
          end else begin
            src_rcv_d = 1'b1;
            state_d   = ACK;
          end
        end
      end
      WAIT_ACK: begin
        // a req_s drop here is tolerated: the
        // transfer still completes on dest_ack
        dest_req_d = 1'b1;
        if (dest_ack) begin
          dest_req_d = 1'b0;
          src_rcv_d  = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: begin
        // hold the ack until the source has
        // visibly withdrawn its request
        if (!req_s) begin
          src_rcv_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        src_rcv_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      state_q  <= IDLE;
      dest_req <= 1'b0;
      src_rcv  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dest_req <= dest_req_d;
      src_rcv  <= src_rcv_d;
      busy     <= (state_d != IDLE);
    end
  end

  // data is only ever loaded on an accepted rise,
  // so it holds across any later src_in activity
  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      dest_out <= '0;
    end else if (cap) begin
      dest_out <= src_in;
    end
  end

`ifdef CDC_HS_DEST_ERR_CNT_EN
  logic fall;
  logic viol;

  assign fall = req_s_d & ~req_s;

  // request withdrawn before the local side
  // finished with the data
  assign viol = fall &
                ((state_q == WAIT_ACK) |
                 (!EXT && (state_q == IDLE)));

  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      err_cnt <= 8'd0;
    end else if (viol && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  // build without the violation counter
`endif

endmodule
